// File: rtl/ddab_seq_if.sv
// rtl/ddab_seq_if.sv - request/result handshake bundle for ddab_seq
interface ddab_seq_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] bin;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       tens;
   logic [3:0]       ones;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, bin, out_ready,
      input  in_ready, out_valid, tens, ones, ovf, busy
   );

   modport slave (
      input  in_valid, bin, out_ready,
      output in_ready, out_valid, tens, ones, ovf, busy
   );
endinterface

// File: rtl/ddab_seq.sv
// rtl/ddab_seq.sv - sequential double-dabble binary to 2-digit BCD converter; macro DDAB_SEQ_SAT_EN saturates results above 99 to 99
module ddab_seq #(
   parameter int WIDTH = 8
) (
   input logic       clk,
   input logic       rst,
   ddab_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [3:0] LAST = 4'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sr_q;
   logic [11:0]        acc_q;
   logic [3:0]         cnt_q;
   logic [3:0]         tens_q, ones_q;
   logic               ovf_q;

   logic [11:0]        acc_adj;
   logic [WIDTH+11:0]  shifted;
   logic [11:0]        acc_next;
   logic [WIDTH-1:0]   sr_next;
   logic               last_shift;

   function automatic logic [3:0] dabble(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // One double-dabble step: correct each digit, then shift the whole chain left
   always_comb begin
      acc_adj  = {dabble(acc_q[11:8]), dabble(acc_q[7:4]), dabble(acc_q[3:0])};
      shifted  = {acc_adj, sr_q} << 1;
      acc_next = shifted[WIDTH+11:WIDTH];
      sr_next  = shifted[WIDTH-1:0];
   end

   assign last_shift = (cnt_q == LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and state-decoded handshake outputs
   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = SHIFT;
         end
         SHIFT: begin
            bus.busy = 1'b1;
            if (last_shift) state_d = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: load on accept, shift while converting, capture digits on the final shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q   <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         tens_q <= '0;
         ones_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.in_valid) begin
            sr_q  <= bus.bin;
            acc_q <= '0;
            cnt_q <= '0;
         end else if (state_q == SHIFT) begin
            sr_q  <= sr_next;
            acc_q <= acc_next;
            cnt_q <= cnt_q + 4'd1;
            if (last_shift) begin
               ovf_q <= (acc_next[11:8] != 4'd0);
`ifdef DDAB_SEQ_SAT_EN
               if (acc_next[11:8] != 4'd0) begin
                  tens_q <= 4'd9;
                  ones_q <= 4'd9;
               end else begin
                  tens_q <= acc_next[7:4];
                  ones_q <= acc_next[3:0];
               end
`else
               tens_q <= acc_next[7:4];
               ones_q <= acc_next[3:0];
`endif
            end
         end
      end
   end

   assign bus.tens = tens_q;
   assign bus.ones = ones_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_ddab_seq.sv
// tb/tb_ddab_seq.sv - self-checking bench for ddab_seq (WIDTH=8), honours DDAB_SEQ_SAT_EN
module tb_ddab_seq;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   ddab_seq_if #(.WIDTH(WIDTH)) bus ();

   ddab_seq #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int         m_left = 0;     // edges of conversion still to go
   bit         m_done = 1'b0;
   logic [3:0] m_tens = '0, m_ones = '0;
   logic       m_ovf  = 1'b0;
   logic [3:0] p_tens, p_ones;
   logic       p_ovf;

   task automatic expect_of(input int b, output logic [3:0] t, output logic [3:0] o, output logic v);
      v = (b > 99);
`ifdef DDAB_SEQ_SAT_EN
      if (b > 99) begin
         t = 4'd9;
         o = 4'd9;
      end else begin
         t = 4'((b % 100) / 10);
         o = 4'(b % 10);
      end
`else
      t = 4'((b % 100) / 10);
      o = 4'(b % 10);
`endif
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0;
         m_done = 1'b0;
         m_tens = '0;
         m_ones = '0;
         m_ovf  = 1'b0;
      end else if (m_done) begin
         if (bus.out_ready) m_done = 1'b0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_tens = p_tens;
            m_ones = p_ones;
            m_ovf  = p_ovf;
         end
      end else if (bus.in_valid) begin
         m_left = WIDTH;
         expect_of(int'(bus.bin), p_tens, p_ones, p_ovf);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      chk("m_in_ready",  32'(bus.in_ready),  32'(!m_done && m_left == 0));
      chk("m_busy",      32'(bus.busy),      32'(m_left > 0));
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_done));
      chk("m_tens",      32'(bus.tens),      32'(m_tens));
      chk("m_ones",      32'(bus.ones),      32'(m_ones));
      chk("m_ovf",       32'(bus.ovf),       32'(m_ovf));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input int b);
      bus.in_valid = 1'b1;
      bus.bin      = 8'(b);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(input string name);
      int n = 0;
      while (!bus.out_valid && n < 20) begin
         step();
         n++;
      end
      chk({name, "_latency"}, 32'(n), 32'(WIDTH));
   endtask

   task automatic lit(input string name, input int t, input int o, input int v);
      chk({name, "_tens"}, 32'(bus.tens), 32'(t));
      chk({name, "_ones"}, 32'(bus.ones), 32'(o));
      chk({name, "_ovf"},  32'(bus.ovf),  32'(v));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.bin       = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      step();
      step();
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      lit("rst", 0, 0, 0);
      rst = 1'b0;
      step();

      request(0);
      chk("zero_busy", 32'(bus.busy), 32'd1);
      chk("zero_in_ready", 32'(bus.in_ready), 32'd0);
      wait_result("zero");
      lit("zero", 0, 0, 0);
      step();

      request(99);
      wait_result("b99");
      lit("b99", 9, 9, 0);
      step();
      request(57);
      wait_result("b57");
      lit("b57", 5, 7, 0);
      step();

      request(255);
      wait_result("b255");
`ifdef DDAB_SEQ_SAT_EN
      lit("b255", 9, 9, 1);
`else
      lit("b255", 5, 5, 1);
`endif
      step();
      request(200);
      wait_result("b200");
`ifdef DDAB_SEQ_SAT_EN
      lit("b200", 9, 9, 1);
`else
      lit("b200", 0, 0, 1);
`endif
      step();

      bus.out_ready = 1'b0;
      request(42);
      wait_result("b42");
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         lit("hold", 4, 2, 0);
         step();
      end
      bus.out_ready = 1'b1;
      step();
      chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rel_in_ready",  32'(bus.in_ready),  32'd1);
      lit("retain", 4, 2, 0);

      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.bin       = 8'd31;
      step();
      for (int i = 0; i < 12; i++) begin
         bus.bin = 8'(8'hA5 ^ (i * 37));
         step();
      end
      bus.in_valid = 1'b0;
      chk("toggle_valid", 32'(bus.out_valid), 32'd1);
      lit("toggle", 3, 1, 0);
      bus.out_ready = 1'b1;
      step();

      request(200);
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      chk("abort_busy",      32'(bus.busy),      32'd0);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
      lit("abort", 0, 0, 0);
      step();
      rst = 1'b0;
      step();
      request(73);
      wait_result("b73");
      lit("b73", 7, 3, 0);
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
